// File: rtl/adj_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adj_pkg
//  Description : Shared types and default timing constants for the time-set
//                controller (set-mode encoding, counter width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package adj_pkg;

    // Set-mode encoding as seen on the mode output. 2'b11 is never a legal state.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_t;

    // Default timing, in 1 kHz clock cycles.
    localparam int c_DEF_DEBOUNCE   = 20;
    localparam int c_DEF_HOLD_DLY   = 500;
    localparam int c_DEF_REPEAT     = 200;
    localparam int c_DEF_TIMEOUT    = 10000;
    localparam int c_DEF_BLINK_HALF = 250;

    // Counter width for a terminal count of n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adj_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : adj_ctrl_if
//  Description : Board-side bundle of the time-set controller.
//                btn_mode / btn_up  : raw push-buttons (async, active-high)
//                adj_hour_p/min_p   : one-cycle adjust pulses to the counter
//                mode               : current set-mode
//                blink              : edit-field blink strobe
//                master = button/display side, slave = controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adj_ctrl_if;
    import adj_pkg::*;

    logic  btn_mode;
    logic  btn_up;
    logic  adj_hour_p;
    logic  adj_min_p;
    mode_t mode;
    logic  blink;

    modport master (
        output btn_mode, btn_up,
        input  adj_hour_p, adj_min_p, mode, blink
    );

    modport slave (
        input  btn_mode, btn_up,
        output adj_hour_p, adj_min_p, mode, blink
    );

endinterface
`default_nettype wire

// File: rtl/adj_ctrl_btn_cond.sv
`default_nettype none
// ============================================================================
//  Module      : btn_cond
//  Description : Push-button conditioner: 2-FF synchronizer, debounce counter
//                and press (rising-edge) detector.
//                clk, rst : 1 kHz clock, synchronous active-high reset
//                i_btn    : raw asynchronous button
//                o_level  : debounced level
//                o_press  : one-cycle pulse on debounced rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_cond
    import adj_pkg::*;
#(
    parameter int DEBOUNCE = c_DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int               c_CW   = cnt_width(DEBOUNCE);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(DEBOUNCE - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_level_d;
    logic [c_CW-1:0] r_cnt;
    // r_fill counts the synchronizer refill after reset; r_armed is set once a
    // genuine released sample has been seen, so a button held through reset
    // does not produce a press until it is released and pressed again.
    logic [1:0]      r_fill;
    logic            r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
            r_fill    <= 2'd0;
            r_armed   <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;

            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end else if (!r_sync2) begin
                r_armed <= 1'b1;
            end

            // Any sample agreeing with the current level restarts the count.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_level & ~r_level_d & r_armed;

endmodule
`default_nettype wire

// File: rtl/adj_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adj_ctrl
//  Description : Button-driven time-set controller. Conditions the mode and
//                up buttons, steps RUN -> SET_HOUR -> SET_MIN -> RUN on mode
//                presses, emits adjust pulses (with hold auto-repeat), falls
//                back to RUN after an idle timeout and blinks the edited field.
//                clk, rst : 1 kHz clock, synchronous active-high reset
//                bus      : adj_ctrl_if.slave (buttons in; pulses, mode,
//                           blink out - all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module adj_ctrl
    import adj_pkg::*;
#(
    parameter int DEBOUNCE   = c_DEF_DEBOUNCE,
    parameter int HOLD_DLY   = c_DEF_HOLD_DLY,
    parameter int REPEAT     = c_DEF_REPEAT,
    parameter int TIMEOUT    = c_DEF_TIMEOUT,
    parameter int BLINK_HALF = c_DEF_BLINK_HALF
) (
    input  logic        clk,
    input  logic        rst,
    adj_ctrl_if.slave   bus
);

    // One hold counter serves both the initial delay and the repeat period.
    localparam int              c_HW          = cnt_width((HOLD_DLY > REPEAT) ? HOLD_DLY : REPEAT);
    localparam int              c_IW          = cnt_width(TIMEOUT);
    localparam int              c_BW          = cnt_width(BLINK_HALF);
    localparam logic [c_HW-1:0] c_HOLD_LAST   = c_HW'(HOLD_DLY - 1);
    localparam logic [c_HW-1:0] c_REP_LAST    = c_HW'(REPEAT - 1);
    localparam logic [c_IW-1:0] c_IDLE_LAST   = c_IW'(TIMEOUT - 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST  = c_BW'(BLINK_HALF - 1);

    logic            w_mode_press;
    logic            w_unused_mode_level;   // only the mode press edge matters
    logic            w_up_press;
    logic            w_up_level;

    mode_t           r_mode;
    mode_t           w_next;
    logic            r_holding;
    logic            r_rep;
    logic [c_HW-1:0] r_hold;
    logic [c_IW-1:0] r_idle;
    logic [c_BW-1:0] r_bcnt;
    logic            r_blink;
    logic            r_hour_p;
    logic            r_min_p;

    logic            w_in_set;
    logic            w_rep_fire;
    logic            w_fire;
    logic            w_hour_fire;
    logic            w_min_fire;
    logic            w_activity;
    logic            w_timeout;
    logic            w_next_set;

    btn_cond #(.DEBOUNCE(DEBOUNCE)) u_btn_mode (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.btn_mode),
        .o_level (w_unused_mode_level),
        .o_press (w_mode_press)
    );

    btn_cond #(.DEBOUNCE(DEBOUNCE)) u_btn_up (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.btn_up),
        .o_level (w_up_level),
        .o_press (w_up_press)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= RUN;
        end else begin
            r_mode <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // Any press or pulse this cycle counts as activity, so an up press landing
    // on the timeout cycle keeps the current set state.
    assign w_activity = w_mode_press | w_up_press | w_fire;
    assign w_timeout  = (r_idle == c_IDLE_LAST) && !w_activity;

    always_comb begin
        w_next = r_mode;
        case (r_mode)
            RUN:      if (w_mode_press) w_next = SET_HOUR;
            SET_HOUR: begin
                if (w_mode_press)   w_next = SET_MIN;
                else if (w_timeout) w_next = RUN;
            end
            SET_MIN:  if (w_mode_press || w_timeout) w_next = RUN;
            default:  w_next = RUN;
        endcase
    end

    // ---------------- FSM: outputs (pre-register) ----------------
    // A mode press suppresses both the fresh press pulse and any repeat pulse.
    always_comb begin
        w_in_set    = (r_mode == SET_HOUR) || (r_mode == SET_MIN);
        w_rep_fire  = r_holding && w_up_level &&
                      (r_hold == (r_rep ? c_REP_LAST : c_HOLD_LAST));
        w_fire      = !w_mode_press && ((w_up_press && w_in_set) || w_rep_fire);
        w_hour_fire = w_fire && (r_mode == SET_HOUR);
        w_min_fire  = w_fire && (r_mode == SET_MIN);
        w_next_set  = (w_next == SET_HOUR) || (w_next == SET_MIN);
    end

    // ---------------- Hold / auto-repeat counter ----------------
    always_ff @(posedge clk) begin
        if (rst || (w_next != r_mode) || !w_up_level) begin
            r_holding <= 1'b0;
            r_rep     <= 1'b0;
            r_hold    <= '0;
        end else if (w_up_press && w_in_set) begin
            r_holding <= 1'b1;
            r_rep     <= 1'b0;
            r_hold    <= '0;
        end else if (r_holding) begin
            if (w_rep_fire) begin
                r_rep  <= 1'b1;
                r_hold <= '0;
            end else begin
                r_hold <= r_hold + c_HW'(1);
            end
        end
    end

    // ---------------- Idle timeout counter ----------------
    always_ff @(posedge clk) begin
        if (rst || (w_next == RUN) || w_activity) begin
            r_idle <= '0;
        end else if (r_idle != c_IDLE_LAST) begin
            r_idle <= r_idle + c_IW'(1);
        end
    end

    // ---------------- Blink ----------------
    // Restarts high on every entry into a set state, including SET_HOUR -> SET_MIN.
    always_ff @(posedge clk) begin
        if (rst || !w_next_set) begin
            r_blink <= 1'b0;
            r_bcnt  <= '0;
        end else if (w_next != r_mode) begin
            r_blink <= 1'b1;
            r_bcnt  <= '0;
        end else if (r_bcnt == c_BLINK_LAST) begin
            r_blink <= ~r_blink;
            r_bcnt  <= '0;
        end else begin
            r_bcnt <= r_bcnt + c_BW'(1);
        end
    end

    // ---------------- Registered pulses ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hour_p <= 1'b0;
            r_min_p  <= 1'b0;
        end else begin
            r_hour_p <= w_hour_fire;
            r_min_p  <= w_min_fire;
        end
    end

    assign bus.adj_hour_p = r_hour_p;
    assign bus.adj_min_p  = r_min_p;
    assign bus.mode       = r_mode;
    assign bus.blink      = r_blink;

endmodule
`default_nettype wire
